sc_phase_sequencer: RTL and testbench

Synchronous controller that sequences the MOS switches of a switched-capacitor charge-transfer stage built from the team's CAPACITOR and NMOS/PMOS transistor primitives. It produces a reset phase, then N non-overlapping two-phase (phi1/phi2) transfer cycles with programmable phase length and dead time, under a start/busy/done handshake. It sits between the digital control logic and the gate drives of the analog switch network in mixed-signal netlists.

---
 rtl/sc_seq_pkg.sv | 26 ++
 rtl/sc_dwell_timer.sv | 30 +++
 rtl/sc_phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_sc_phase_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_seq_pkg.sv
// Shared encodings and helpers for the switched-capacitor phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RST  = 3'd1;
    localparam state_t ST_DEAD = 3'd2;
    localparam state_t ST_PHI1 = 3'd3;
    localparam state_t ST_PHI2 = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Where a DEAD gap hands over once its dwell expires.
    typedef logic [1:0] succ_t;

    localparam succ_t SUCC_PHI1 = 2'd0;
    localparam succ_t SUCC_PHI2 = 2'd1;
    localparam succ_t SUCC_DONE = 2'd2;

    function automatic int unsigned eff_len(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/sc_dwell_timer.sv
// Loadable down-counter measuring how long the sequencer dwells in a state.
// Latency: load visible the clock after load; zero is combinational on value.
// Backpressure: none; saturates at zero.
module sc_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign value = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/sc_phase_sequencer.sv
// Drives reset / non-overlapping phi1-phi2 gates for a switched-cap transfer stage.
// Latency: start at edge k -> busy/phi_rst from k+1; busy lasts L+D+N(2L+2D)+1 clocks.
// Backpressure: start ignored while busy; abort returns to IDLE on the next edge.
module sc_phase_sequencer
    import sc_seq_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int PH_W   = 8,
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_cycles,
    input  logic [PH_W-1:0]   ph_len,
    input  logic [DEAD_W-1:0] dead,
    output logic              busy,
    output logic              done,
    output logic              phi_rst,
    output logic              phi1,
    output logic              phi2,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int TW = (PH_W > DEAD_W) ? PH_W : DEAD_W;

    state_t            state;
    state_t            state_nxt;
    succ_t             succ;
    succ_t             succ_nxt;
    logic [CNT_W-1:0]  n_lat;
    logic [PH_W-1:0]   ph_lat;
    logic [DEAD_W-1:0] dead_lat;
    logic [PH_W-1:0]   len_src;
    logic              tmr_load;
    logic [TW-1:0]     tmr_load_val;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;
    logic              accept;
    logic              unused_tmr;

    assign accept     = (state == ST_IDLE) && start;
    assign unused_tmr = ^tmr_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            succ  <= SUCC_PHI1;
        end else begin
            state <= state_nxt;
            succ  <= succ_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat     <= '0;
            ph_lat    <= '0;
            dead_lat  <= '0;
            cycle_cnt <= '0;
        end else if (accept) begin
            n_lat     <= n_cycles;
            ph_lat    <= ph_len;
            dead_lat  <= dead;
            cycle_cnt <= '0;
        end else if (state == ST_PHI2 && tmr_zero && !abort) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        succ_nxt  = succ;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RST;
            end
            ST_RST: begin
                if (tmr_zero) begin
                    state_nxt = ST_DEAD;
                    succ_nxt  = (n_lat == '0) ? SUCC_DONE : SUCC_PHI1;
                end
            end
            ST_PHI1: begin
                if (tmr_zero) begin
                    state_nxt = ST_DEAD;
                    succ_nxt  = SUCC_PHI2;
                end
            end
            ST_PHI2: begin
                // The count bumps on this same edge, so compare against its next value.
                if (tmr_zero) begin
                    state_nxt = ST_DEAD;
                    succ_nxt  = ((cycle_cnt + CNT_W'(1)) == n_lat) ? SUCC_DONE : SUCC_PHI1;
                end
            end
            ST_DEAD: begin
                if (tmr_zero) begin
                    unique case (succ)
                        SUCC_PHI1: state_nxt = ST_PHI1;
                        SUCC_PHI2: state_nxt = ST_PHI2;
                        default:   state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    // New phase length comes straight from the input on the accepting edge.
    always_comb begin
        len_src      = (state == ST_IDLE) ? ph_len : ph_lat;
        tmr_load     = (state_nxt != state);
        tmr_load_val = '0;
        unique case (state_nxt)
            ST_RST, ST_PHI1, ST_PHI2: tmr_load_val = TW'(eff_len(32'(len_src)) - 32'd1);
            ST_DEAD:                  tmr_load_val = TW'(eff_len(32'(dead_lat)) - 32'd1);
            default:                  tmr_load_val = '0;
        endcase
    end

    sc_dwell_timer #(
        .W (TW)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        phi_rst = (state == ST_RST);
        phi1    = (state == ST_PHI1);
        phi2    = (state == ST_PHI2);
    end

endmodule

// File: tb/tb_sc_phase_sequencer.sv
// Scoreboard bench: each accepted start expands the phase schedule into a per-clock queue.
module tb_sc_phase_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       phi_rst;
        logic       phi1;
        logic       phi2;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] n_cycles;
    logic [7:0] ph_len;
    logic [3:0] dead;
    logic       busy;
    logic       done;
    logic       phi_rst;
    logic       phi1;
    logic       phi2;
    logic [7:0] cycle_cnt;

    obs_t       exp_q[$];
    obs_t       tr[$];
    obs_t       act;
    obs_t       expv;
    logic [7:0] last_cnt;
    bit         mon_en;
    int         vectors;
    int         miscompares;

    sc_phase_sequencer #(
        .CNT_W  (8),
        .PH_W   (8),
        .DEAD_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .n_cycles  (n_cycles),
        .ph_len    (ph_len),
        .dead      (dead),
        .busy      (busy),
        .done      (done),
        .phi_rst   (phi_rst),
        .phi1      (phi1),
        .phi2      (phi2),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(bit b, bit d, bit r, bit p1, bit p2, logic [7:0] c);
        obs_t o;
        o.busy    = b;
        o.done    = d;
        o.phi_rst = r;
        o.phi1    = p1;
        o.phi2    = p2;
        o.cnt     = c;
        return o;
    endfunction

    // Reference schedule: one entry per busy clock, straight from the phase ordering rules.
    task automatic build(input int pl, input int dl, input int n);
        int         L;
        int         D;
        logic [7:0] c;
        L = (pl == 0) ? 1 : pl;
        D = (dl == 0) ? 1 : dl;
        c = 8'd0;
        tr.delete();
        repeat (L) tr.push_back(mk(1, 0, 1, 0, 0, c));
        repeat (D) tr.push_back(mk(1, 0, 0, 0, 0, c));
        for (int k = 0; k < n; k++) begin
            repeat (L) tr.push_back(mk(1, 0, 0, 1, 0, c));
            repeat (D) tr.push_back(mk(1, 0, 0, 0, 0, c));
            repeat (L) tr.push_back(mk(1, 0, 0, 0, 1, c));
            c = c + 8'd1;
            repeat (D) tr.push_back(mk(1, 0, 0, 0, 0, c));
        end
        tr.push_back(mk(1, 1, 0, 0, 0, c));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            act = {busy, done, phi_rst, phi1, phi2, cycle_cnt};
            if (exp_q.size() > 0) expv = exp_q.pop_front();
            else                  expv = mk(0, 0, 0, 0, 0, last_cnt);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL seq_vec t=%0t got busy=%b done=%b rst=%b p1=%b p2=%b cnt=%0d want busy=%b done=%b rst=%b p1=%b p2=%b cnt=%0d",
                         $time, act.busy, act.done, act.phi_rst, act.phi1, act.phi2, act.cnt,
                         expv.busy, expv.done, expv.phi_rst, expv.phi1, expv.phi2, expv.cnt);
            end
            vectors++;
            if ((32'(phi_rst) + 32'(phi1) + 32'(phi2)) > 1) begin
                miscompares++;
                $display("FAIL phase_overlap t=%0t got rst=%b p1=%b p2=%b want at most one high",
                         $time, phi_rst, phi1, phi2);
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE clock afterwards.
    // aidx: -1 none, -2 abort in DONE, -3 random abort clock, >=0 abort at that schedule index.
    task automatic start_run(input int pl, input int dl, input int n, input int aidx, input bit with_abort);
        int last;
        ph_len   = 8'(pl);
        dead     = 4'(dl);
        n_cycles = 8'(n);
        start    = 1'b1;
        abort    = with_abort;
        build(pl, dl, n);
        if (aidx == -2) aidx = tr.size() - 1;
        if (aidx == -3) aidx = $urandom_range(0, tr.size() - 1);
        if (aidx >= 0 && tr[aidx].phi2) aidx = aidx - 1;
        last = (aidx >= 0) ? aidx : tr.size() - 1;
        @(posedge clk);
        for (int i = 0; i <= last; i++) exp_q.push_back(tr[i]);
        last_cnt = tr[last].cnt;
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            ph_len   = 8'($urandom);
            dead     = 4'($urandom);
            n_cycles = 8'($urandom);
            abort    = (i == aidx);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic reset_mid_phi2();
        ph_len   = 8'd2;
        dead     = 4'd1;
        n_cycles = 8'd3;
        start    = 1'b1;
        build(2, 1, 3);
        @(posedge clk);
        foreach (tr[i]) exp_q.push_back(tr[i]);
        last_cnt = 8'd3;
        #1;
        start = 1'b0;
        // Index 13 is the last clock of the second PHI2 (cycle_cnt already 1).
        repeat (14) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        vectors++;
        if ({busy, done, phi_rst, phi1, phi2, cycle_cnt} !== 13'd0) begin
            miscompares++;
            $display("FAIL async_reset got busy=%b done=%b rst=%b p1=%b p2=%b cnt=%0d want all zero",
                     busy, done, phi_rst, phi1, phi2, cycle_cnt);
        end
        exp_q.delete();
        last_cnt = 8'd0;
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t, want run to finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        last_cnt    = 8'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        n_cycles    = 8'd0;
        ph_len      = 8'd0;
        dead        = 4'd0;
        #3;
        vectors++;
        if ({busy, done, phi_rst, phi1, phi2, cycle_cnt} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b rst=%b p1=%b p2=%b cnt=%0d want all zero",
                     busy, done, phi_rst, phi1, phi2, cycle_cnt);
        end
        #9;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        start_run(2, 1, 2, -1, 1'b0);
        start_run(0, 0, 1, -1, 1'b0);
        start_run(3, 2, 0, -1, 1'b0);
        // Second PHI1 of L=3, D=2 begins at index 3L+3D = 15.
        start_run(3, 2, 4, 16, 1'b0);
        start_run(2, 2, 1, -1, 1'b0);
        start_run(2, 1, 1, -2, 1'b0);
        start_run(1, 1, 1, -1, 1'b1);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        reset_mid_phi2();

        for (int r = 0; r < 30; r++) begin
            start_run($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0) ? -3 : -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
